// File: rtl/cfr_axil_ipif_bridge.sv
// rtl/cfr_axil_ipif_bridge.sv - AXI4-Lite slave to IPIF master bridge, independent write/read engines
// Optional ack timeout enabled by defining CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN.
module cfr_axil_ipif_bridge #(
   parameter int IPIF_ADDR_WIDTH = 15,
   parameter int IPIF_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [IPIF_ADDR_WIDTH+1:0]   s_axil_awaddr,
   input  logic                         s_axil_awvalid,
   output logic                         s_axil_awready,
   input  logic [IPIF_DATA_WIDTH-1:0]   s_axil_wdata,
   input  logic [IPIF_DATA_WIDTH/8-1:0] s_axil_wstrb,
   input  logic                         s_axil_wvalid,
   output logic                         s_axil_wready,
   output logic [1:0]                   s_axil_bresp,
   output logic                         s_axil_bvalid,
   input  logic                         s_axil_bready,
   input  logic [IPIF_ADDR_WIDTH+1:0]   s_axil_araddr,
   input  logic                         s_axil_arvalid,
   output logic                         s_axil_arready,
   output logic [IPIF_DATA_WIDTH-1:0]   s_axil_rdata,
   output logic [1:0]                   s_axil_rresp,
   output logic                         s_axil_rvalid,
   input  logic                         s_axil_rready,
   output logic [IPIF_ADDR_WIDTH-1:0]   wr_addr,
   output logic                         wr_req,
   output logic [IPIF_DATA_WIDTH-1:0]   wr_data,
   input  logic                         wr_ack,
   output logic [IPIF_ADDR_WIDTH-1:0]   rd_addr,
   output logic                         rd_req,
   input  logic [IPIF_DATA_WIDTH-1:0]   rd_data,
   input  logic                         rd_ack
);

   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   logic                       aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic                       awready_nxt, wready_nxt, bvalid_nxt, wr_req_nxt;
   logic [1:0]                 bresp_nxt, rresp_nxt;
   logic [IPIF_ADDR_WIDTH-1:0] wr_addr_nxt, rd_addr_nxt;
   logic [IPIF_DATA_WIDTH-1:0] wr_data_nxt, rdata_nxt;
   logic                       arready_nxt, rvalid_nxt, rd_req_nxt;
   logic                       aw_hs, w_hs, ar_hs;

   // Byte lanes and sub-word address bits carry no meaning on the word-wide IPIF.
   logic unused_bits;
   assign unused_bits = ^{s_axil_wstrb, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
   logic [15:0] w_cnt, w_cnt_nxt, r_cnt, r_cnt_nxt;
`endif

   assign aw_hs = s_axil_awvalid & s_axil_awready;
   assign w_hs  = s_axil_wvalid  & s_axil_wready;
   assign ar_hs = s_axil_arvalid & s_axil_arready;

   always_comb begin
      w_state_nxt = w_state;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      awready_nxt = s_axil_awready;
      wready_nxt  = s_axil_wready;
      wr_addr_nxt = wr_addr;
      wr_data_nxt = wr_data;
      wr_req_nxt  = 1'b0;
      bvalid_nxt  = s_axil_bvalid;
      bresp_nxt   = s_axil_bresp;
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
      w_cnt_nxt   = w_cnt;
`endif
      case (w_state)
         W_IDLE: begin
            if (aw_hs) begin
               wr_addr_nxt = s_axil_awaddr[IPIF_ADDR_WIDTH+1:2];
               aw_done_nxt = 1'b1;
            end
            if (w_hs) begin
               wr_data_nxt = s_axil_wdata;
               w_done_nxt  = 1'b1;
            end
            awready_nxt = !aw_done_nxt;
            wready_nxt  = !w_done_nxt;
            if (aw_done_nxt && w_done_nxt) begin
               w_state_nxt = W_WAIT;
               wr_req_nxt  = 1'b1;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
               w_cnt_nxt   = 16'd0;
`endif
            end
         end
         W_WAIT: begin
            if (wr_ack) begin
               w_state_nxt = W_RESP;
               bvalid_nxt  = 1'b1;
               bresp_nxt   = 2'b00;
            end
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
            else if (w_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt = W_RESP;
               bvalid_nxt  = 1'b1;
               bresp_nxt   = 2'b10;
            end else begin
               w_cnt_nxt = w_cnt + 16'd1;
            end
`endif
         end
         W_RESP: begin
            if (s_axil_bvalid && s_axil_bready) begin
               w_state_nxt = W_IDLE;
               bvalid_nxt  = 1'b0;
               bresp_nxt   = 2'b00;
               awready_nxt = 1'b1;
               wready_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_nxt = r_state;
      arready_nxt = s_axil_arready;
      rd_addr_nxt = rd_addr;
      rd_req_nxt  = 1'b0;
      rvalid_nxt  = s_axil_rvalid;
      rdata_nxt   = s_axil_rdata;
      rresp_nxt   = s_axil_rresp;
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
      r_cnt_nxt   = r_cnt;
`endif
      case (r_state)
         R_IDLE: begin
            arready_nxt = 1'b1;
            if (ar_hs) begin
               rd_addr_nxt = s_axil_araddr[IPIF_ADDR_WIDTH+1:2];
               arready_nxt = 1'b0;
               rd_req_nxt  = 1'b1;
               r_state_nxt = R_WAIT;
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
               r_cnt_nxt   = 16'd0;
`endif
            end
         end
         R_WAIT: begin
            if (rd_ack) begin
               r_state_nxt = R_RESP;
               rvalid_nxt  = 1'b1;
               rdata_nxt   = rd_data;
               rresp_nxt   = 2'b00;
            end
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
            else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
               r_state_nxt = R_RESP;
               rvalid_nxt  = 1'b1;
               rdata_nxt   = '0;
               rresp_nxt   = 2'b10;
            end else begin
               r_cnt_nxt = r_cnt + 16'd1;
            end
`endif
         end
         R_RESP: begin
            if (s_axil_rvalid && s_axil_rready) begin
               r_state_nxt = R_IDLE;
               rvalid_nxt  = 1'b0;
               arready_nxt = 1'b1;
            end
         end
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_state        <= W_IDLE;
         r_state        <= R_IDLE;
         aw_done        <= 1'b0;
         w_done         <= 1'b0;
         s_axil_awready <= 1'b0;
         s_axil_wready  <= 1'b0;
         s_axil_bvalid  <= 1'b0;
         s_axil_bresp   <= 2'b00;
         s_axil_arready <= 1'b0;
         s_axil_rvalid  <= 1'b0;
         s_axil_rresp   <= 2'b00;
         s_axil_rdata   <= '0;
         wr_addr        <= '0;
         wr_data        <= '0;
         wr_req         <= 1'b0;
         rd_addr        <= '0;
         rd_req         <= 1'b0;
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
         w_cnt          <= 16'd0;
         r_cnt          <= 16'd0;
`endif
      end else begin
         w_state        <= w_state_nxt;
         r_state        <= r_state_nxt;
         aw_done        <= aw_done_nxt;
         w_done         <= w_done_nxt;
         s_axil_awready <= awready_nxt;
         s_axil_wready  <= wready_nxt;
         s_axil_bvalid  <= bvalid_nxt;
         s_axil_bresp   <= bresp_nxt;
         s_axil_arready <= arready_nxt;
         s_axil_rvalid  <= rvalid_nxt;
         s_axil_rresp   <= rresp_nxt;
         s_axil_rdata   <= rdata_nxt;
         wr_addr        <= wr_addr_nxt;
         wr_data        <= wr_data_nxt;
         wr_req         <= wr_req_nxt;
         rd_addr        <= rd_addr_nxt;
         rd_req         <= rd_req_nxt;
`ifdef CFR_AXIL_IPIF_BRIDGE_TIMEOUT_EN
         w_cnt          <= w_cnt_nxt;
         r_cnt          <= r_cnt_nxt;
`endif
      end
   end

endmodule
